// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the M-stage load/store engine: op and state encodings,
// exception codes, and byte-lane helpers.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_EXC  = 2'd3
  } mau_state_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_word(input mem_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input mem_op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic [4:0] exc_code_for(input mem_op_e op);
    return is_store(op) ? EXC_ADES : EXC_ADEL;
  endfunction

  function automatic logic [3:0] calc_byteen(input mem_op_e op, input logic [1:0] a);
    if (is_word(op)) return 4'b1111;
    if (is_half(op)) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b0001 << a;
  endfunction

  function automatic logic [31:0] calc_wdata(input mem_op_e op, input logic [31:0] wd);
    if (is_word(op)) return wd;
    if (is_half(op)) return {2{wd[15:0]}};
    return {4{wd[7:0]}};
  endfunction

  function automatic logic in_window(input logic [31:0] a, input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory / IO bus between the load/store engine (master) and the memory system (slave).
interface mem_access_unit_if;
  // bus_req rises with all other bus_* fields valid and holds them stable until the
  // cycle bus_ack is high; bus_rdata is valid in that same ack cycle.
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_ext.sv
// Load data lane select and sign/zero extension from the raw bus word.
module mem_load_ext
  import mem_access_unit_pkg::*;
(
  input  mem_op_e     i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[8*i_addr_lo +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = '0;
    case (i_op)
      OP_LW:   o_data = i_rdata;
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'd0, w_half};
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'd0, w_byte};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store engine: address exception check, req/ack bus transaction, load extension.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] DM_BASE        = 32'h0000_0000,
  parameter logic [31:0] DM_END         = 32'h0000_2FFF,
  parameter logic [31:0] IO_BASE        = 32'h0000_7F00,
  parameter logic [31:0] IO_END         = 32'h0000_7F1F,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_valid,
  input  logic [2:0]         m_op,
  input  logic [31:0]        m_addr,
  input  logic               m_addr_ov,
  input  logic [31:0]        m_wdata,
  input  logic               m_flush,
  mem_access_unit_if.master  bus,
  output logic               mem_stall,
  output logic               ld_valid,
  output logic [31:0]        ld_data,
  output logic               exc_valid,
  output logic [4:0]         exc_code,
  output mau_state_e         o_dbg_state
);

  mau_state_e  r_state, w_next;
  mem_op_e     r_op;
  logic [31:0] r_addr, r_wdata, r_rdata, w_ld_ext;
  logic [3:0]  r_byteen;
  logic [4:0]  r_exc_code;
  mem_op_e     w_op;
  logic        w_misaligned, w_in_dm, w_in_io, w_exc, w_timeout;

  assign w_op         = mem_op_e'(m_op);
  assign w_misaligned = is_word(w_op) ? (m_addr[1:0] != 2'b00) :
                        is_half(w_op) ? m_addr[0] : 1'b0;
  assign w_in_dm      = in_window(m_addr, DM_BASE, DM_END);
  assign w_in_io      = in_window(m_addr, IO_BASE, IO_END);
  // All causes map to the same AdEL/AdES code, so their priority order never changes the result.
  assign w_exc        = m_addr_ov | w_misaligned | (!w_in_dm && !w_in_io) |
                        (w_in_io && !is_word(w_op));

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_tmo_cnt <= '0;
    else if (r_state != ST_REQ) r_tmo_cnt <= '0;
    else                       r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_timeout = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (m_valid) w_next = w_exc ? ST_EXC : ST_REQ;
      ST_REQ: begin
        if (bus.bus_ack)    w_next = ST_DONE;
        else if (w_timeout) w_next = ST_EXC;
      end
      ST_DONE: w_next = ST_IDLE;
      ST_EXC:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (m_flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_LW;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_byteen   <= '0;
      r_rdata    <= '0;
      r_exc_code <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_next == ST_REQ) begin
        r_op     <= w_op;
        r_addr   <= m_addr;
        r_byteen <= calc_byteen(w_op, m_addr[1:0]);
        r_wdata  <= calc_wdata(w_op, m_wdata);
      end
      if (w_next == ST_EXC)
        r_exc_code <= (r_state == ST_IDLE) ? exc_code_for(w_op) : exc_code_for(r_op);
      if (r_state == ST_REQ && w_next == ST_DONE)
        r_rdata <= bus.bus_rdata;
    end
  end

  mem_load_ext u_load_ext (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_rdata   (r_rdata),
    .o_data    (w_ld_ext)
  );

  always_comb begin
    mem_stall      = 1'b0;
    ld_valid       = 1'b0;
    ld_data        = '0;
    exc_valid      = 1'b0;
    bus.bus_req    = 1'b0;
    bus.bus_we     = 1'b0;
    bus.bus_addr   = '0;
    bus.bus_byteen = '0;
    bus.bus_wdata  = '0;
    case (r_state)
      // Reset term keeps every output low while reset is held, even with m_valid up.
      ST_IDLE: mem_stall = m_valid & !m_flush & reset;
      ST_REQ: begin
        mem_stall      = 1'b1;
        bus.bus_req    = 1'b1;
        bus.bus_we     = is_store(r_op);
        bus.bus_addr   = {r_addr[31:2], 2'b00};
        bus.bus_byteen = r_byteen;
        bus.bus_wdata  = r_wdata;
      end
      ST_DONE: if (!is_store(r_op) && !m_flush) begin
        ld_valid = 1'b1;
        ld_data  = w_ld_ext;
      end
      ST_EXC:  exc_valid = !m_flush;
      default: ;
    endcase
  end

  assign exc_code    = r_exc_code;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: reference model and expected-result queue per access.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_valid = 1'b0;
  logic [2:0]  m_op = 3'd0;
  logic [31:0] m_addr = '0;
  logic        m_addr_ov = 1'b0;
  logic [31:0] m_wdata = '0;
  logic        m_flush = 1'b0;
  logic        mem_stall, ld_valid, exc_valid;
  logic [31:0] ld_data;
  logic [4:0]  exc_code;
  mau_state_e  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] exp_q[$];

  mem_access_unit_if bus_if();

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_addr_ov(m_addr_ov), .m_wdata(m_wdata), .m_flush(m_flush), .bus(bus_if.master),
    .mem_stall(mem_stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .o_dbg_state(dbg_state)
  );

  initial begin
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = '0;
  end

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd5) return 4;
    if (op == 3'd1 || op == 3'd2 || op == 3'd6) return 2;
    return 1;
  endfunction

  function automatic logic [4:0] m_exc(input logic [2:0] op, input logic [31:0] addr, input logic ov);
    int sz;
    logic in_dm, in_io, bad;
    sz = m_size(op);
    in_dm = addr <= 32'h0000_2FFF;
    in_io = (addr >= 32'h0000_7F00) && (addr <= 32'h0000_7F1F);
    bad = ov || ((addr[1:0] & 2'(sz - 1)) != 2'b00) || !(in_dm || in_io) || (in_io && sz != 4);
    return bad ? ((op >= 3'd5) ? 5'd5 : 5'd4) : 5'd0;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * addr[1:0]);
    case (op)
      3'd0:    return rd;
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd2:    return {16'd0, sh[15:0]};
      3'd3:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'd0, sh[7:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] addr);
    return 4'(((1 << m_size(op)) - 1) << addr[1:0]);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] op, input logic [31:0] wd);
    if (m_size(op) == 4) return wd;
    if (m_size(op) == 2) return {wd[15:0], wd[15:0]};
    return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
  endfunction

  // ---------------- driver + monitor ----------------
  task automatic do_access(input logic [2:0] op, input logic [31:0] addr, input logic ov,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_cyc,
                           input logic tmo, output int stall_cnt, output int req_cnt);
    logic [4:0]  ecode;
    logic [39:0] item;
    logic        done, st;
    st = (op >= 3'd5);
    ecode = tmo ? (st ? 5'd5 : 5'd4) : m_exc(op, addr, ov);
    if (ecode != 5'd0) exp_q.push_back({8'h02, 27'd0, ecode});
    else if (st)       exp_q.push_back({8'h00, 32'd0});
    else               exp_q.push_back({8'h01, m_ld(op, addr, rd)});
    @(negedge clk);
    m_valid = 1'b1; m_op = op; m_addr = addr; m_addr_ov = ov; m_wdata = wd; m_flush = 1'b0;
    stall_cnt = 0; req_cnt = 0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (!mem_stall) begin
        item = exp_q.pop_front();
        vectors += 2;
        if (ld_valid !== (item[39:32] == 8'h01)) begin
          $display("FAIL ld_valid op=%0d addr=%h: got %b want %b", op, addr, ld_valid, item[39:32] == 8'h01);
          miscompares++;
        end
        if (exc_valid !== (item[39:32] == 8'h02)) begin
          $display("FAIL exc_valid op=%0d addr=%h: got %b want %b", op, addr, exc_valid, item[39:32] == 8'h02);
          miscompares++;
        end
        if (item[39:32] == 8'h01) begin
          vectors++;
          if (ld_data !== item[31:0]) begin
            $display("FAIL ld_data op=%0d addr=%h: got %h want %h", op, addr, ld_data, item[31:0]);
            miscompares++;
          end
        end
        if (item[39:32] == 8'h02) begin
          vectors++;
          if (exc_code !== item[4:0]) begin
            $display("FAIL exc_code op=%0d addr=%h: got %0d want %0d", op, addr, exc_code, item[4:0]);
            miscompares++;
          end
        end
        done = 1'b1;
      end else begin
        stall_cnt++;
        if (bus_if.bus_req) begin
          req_cnt++;
          vectors += 3;
          if (bus_if.bus_we !== st) begin
            $display("FAIL bus_we op=%0d: got %b want %b", op, bus_if.bus_we, st);
            miscompares++;
          end
          if (bus_if.bus_addr !== {addr[31:2], 2'b00}) begin
            $display("FAIL bus_addr op=%0d: got %h want %h", op, bus_if.bus_addr, {addr[31:2], 2'b00});
            miscompares++;
          end
          if (bus_if.bus_byteen !== m_be(op, addr)) begin
            $display("FAIL bus_byteen op=%0d addr=%h: got %b want %b", op, addr, bus_if.bus_byteen, m_be(op, addr));
            miscompares++;
          end
          if (st) begin
            vectors++;
            if (bus_if.bus_wdata !== m_wd(op, wd)) begin
              $display("FAIL bus_wdata op=%0d: got %h want %h", op, bus_if.bus_wdata, m_wd(op, wd));
              miscompares++;
            end
          end
          if (req_cnt == ack_cyc) begin
            bus_if.bus_ack = 1'b1;
            bus_if.bus_rdata = rd;
          end
        end
        @(negedge clk);
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = '0;
      end
    end
    if (!done) begin
      $display("FAIL access_timeout op=%0d addr=%h: got no completion want completion in 40 cycles", op, addr);
      vectors++;
      miscompares++;
      exp_q.delete();
    end
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_valid = 1'b0; m_flush = 1'b0; m_addr_ov = 1'b0;
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      $display("FAIL %s: got %0d want %0d", name, got, want);
      miscompares++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    m_valid = 1'b1;
    #1;
    vectors += 7;
    if (bus_if.bus_req !== 1'b0) begin $display("FAIL reset_bus_req: got %b want 0", bus_if.bus_req); miscompares++; end
    if (mem_stall !== 1'b0) begin $display("FAIL reset_mem_stall: got %b want 0", mem_stall); miscompares++; end
    if (ld_valid !== 1'b0) begin $display("FAIL reset_ld_valid: got %b want 0", ld_valid); miscompares++; end
    if (ld_data !== 32'd0) begin $display("FAIL reset_ld_data: got %h want 0", ld_data); miscompares++; end
    if (exc_valid !== 1'b0) begin $display("FAIL reset_exc_valid: got %b want 0", exc_valid); miscompares++; end
    if (exc_code !== 5'd0) begin $display("FAIL reset_exc_code: got %0d want 0", exc_code); miscompares++; end
    if (dbg_state !== ST_IDLE) begin $display("FAIL reset_state: got %0d want 0", dbg_state); miscompares++; end
    @(negedge clk);
    m_valid = 1'b0;
    reset = 1'b1;
    go_idle(1);
  endtask

  task automatic test_store_word();
    int st, rq;
    do_access(3'd5, 32'h1004, 1'b0, 32'h1234_5678, 32'd0, 2, 1'b0, st, rq);
    check_cnt("sw_stall_cycles", st, 3);
    check_cnt("sw_req_cycles", rq, 2);
    go_idle(1);
  endtask

  task automatic test_load_ext();
    int st, rq;
    do_access(3'd3, 32'h1003, 1'b0, 32'd0, 32'h80FF_0000, 1, 1'b0, st, rq);
    check_cnt("lb_latency_stall", st, 2);
    do_access(3'd4, 32'h1003, 1'b0, 32'd0, 32'h80FF_0000, 1, 1'b0, st, rq);
    do_access(3'd6, 32'h1002, 1'b0, 32'hABCD_1234, 32'd0, 1, 1'b0, st, rq);
    do_access(3'd7, 32'h1001, 1'b0, 32'h0000_00A5, 32'd0, 3, 1'b0, st, rq);
    do_access(3'd1, 32'h1002, 1'b0, 32'd0, 32'h8001_7FFF, 1, 1'b0, st, rq);
    do_access(3'd2, 32'h1000, 1'b0, 32'd0, 32'h0000_F00D, 2, 1'b0, st, rq);
    do_access(3'd0, 32'h2FFC, 1'b0, 32'd0, 32'hDEAD_BEEF, 1, 1'b0, st, rq);
    do_access(3'd0, 32'h7F1C, 1'b0, 32'd0, 32'h0000_0042, 1, 1'b0, st, rq);
    go_idle(1);
  endtask

  task automatic test_exceptions();
    int st, rq;
    do_access(3'd1, 32'h1001, 1'b0, 32'd0, 32'd0, 1, 1'b0, st, rq);
    check_cnt("lh_misaligned_req", rq, 0);
    check_cnt("lh_misaligned_stall", st, 1);
    do_access(3'd7, 32'h7F00, 1'b0, 32'd0, 32'd0, 1, 1'b0, st, rq);
    check_cnt("sb_io_req", rq, 0);
    do_access(3'd5, 32'h3000, 1'b0, 32'd0, 32'd0, 1, 1'b0, st, rq);
    check_cnt("sw_range_req", rq, 0);
    do_access(3'd3, 32'h2FFF, 1'b0, 32'd0, 32'h7700_0000, 1, 1'b0, st, rq);
    go_idle(1);
  endtask

  task automatic test_overflow();
    int st, rq;
    do_access(3'd5, 32'h1000, 1'b1, 32'h5555_5555, 32'd0, 1, 1'b0, st, rq);
    check_cnt("sw_ov_req", rq, 0);
    do_access(3'd0, 32'h1000, 1'b1, 32'd0, 32'd0, 1, 1'b0, st, rq);
    check_cnt("lw_ov_req", rq, 0);
    go_idle(1);
  endtask

  task automatic test_flush();
    @(negedge clk);
    m_valid = 1'b1; m_op = 3'd0; m_addr = 32'h1008; m_addr_ov = 1'b0; m_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_flush = 1'b1;
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = 32'hCAFE_F00D;
    #1;
    vectors++;
    if (bus_if.bus_req !== 1'b1) begin $display("FAIL flush_req_before: got %b want 1", bus_if.bus_req); miscompares++; end
    @(negedge clk);
    m_flush = 1'b0; m_valid = 1'b0;
    bus_if.bus_ack = 1'b0;
    #1;
    vectors += 4;
    if (bus_if.bus_req !== 1'b0) begin $display("FAIL flush_req_after: got %b want 0", bus_if.bus_req); miscompares++; end
    if (dbg_state !== ST_IDLE) begin $display("FAIL flush_state: got %0d want 0", dbg_state); miscompares++; end
    if (ld_valid !== 1'b0) begin $display("FAIL flush_ld_valid: got %b want 0", ld_valid); miscompares++; end
    if (exc_valid !== 1'b0) begin $display("FAIL flush_exc_valid: got %b want 0", exc_valid); miscompares++; end
    @(negedge clk);
    m_valid = 1'b1; m_op = 3'd1; m_addr = 32'h1001; m_flush = 1'b1;
    #1;
    vectors++;
    if (mem_stall !== 1'b0) begin $display("FAIL flush_idle_stall: got %b want 0", mem_stall); miscompares++; end
    @(negedge clk);
    m_valid = 1'b0; m_flush = 1'b0;
    #1;
    vectors += 2;
    if (exc_valid !== 1'b0) begin $display("FAIL flush_idle_exc: got %b want 0", exc_valid); miscompares++; end
    if (dbg_state !== ST_IDLE) begin $display("FAIL flush_idle_state: got %0d want 0", dbg_state); miscompares++; end
    go_idle(1);
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    m_valid = 1'b1; m_op = 3'd5; m_addr = 32'h1010; m_wdata = 32'h1111_2222;
    @(negedge clk);
    #1;
    vectors++;
    if (bus_if.bus_req !== 1'b1) begin $display("FAIL rst_mid_req_up: got %b want 1", bus_if.bus_req); miscompares++; end
    #1;
    reset = 1'b0;
    #1;
    vectors += 6;
    if (bus_if.bus_req !== 1'b0) begin $display("FAIL rst_mid_bus_req: got %b want 0", bus_if.bus_req); miscompares++; end
    if (bus_if.bus_addr !== 32'd0) begin $display("FAIL rst_mid_bus_addr: got %h want 0", bus_if.bus_addr); miscompares++; end
    if (mem_stall !== 1'b0) begin $display("FAIL rst_mid_stall: got %b want 0", mem_stall); miscompares++; end
    if (exc_code !== 5'd0) begin $display("FAIL rst_mid_exc_code: got %0d want 0", exc_code); miscompares++; end
    if (ld_valid !== 1'b0 || exc_valid !== 1'b0) begin
      $display("FAIL rst_mid_pulses: got %b%b want 00", ld_valid, exc_valid); miscompares++;
    end
    if (dbg_state !== ST_IDLE) begin $display("FAIL rst_mid_state: got %0d want 0", dbg_state); miscompares++; end
    @(negedge clk);
    m_valid = 1'b0;
    reset = 1'b1;
    go_idle(1);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int st, rq;
    do_access(3'd0, 32'h1020, 1'b0, 32'd0, 32'd0, 0, 1'b1, st, rq);
    check_cnt("timeout_req_cycles", rq, 4);
    #0;
    vectors++;
    if (bus_if.bus_req !== 1'b0) begin $display("FAIL timeout_req_drop: got %b want 0", bus_if.bus_req); miscompares++; end
    go_idle(1);
  endtask
`else
  task automatic test_timeout();
    int st, rq;
    do_access(3'd0, 32'h1020, 1'b0, 32'd0, 32'h0BAD_F00D, 25, 1'b0, st, rq);
    check_cnt("long_wait_req_cycles", rq, 25);
    go_idle(1);
  endtask
`endif

  task automatic test_back_to_back();
    int st, rq, ack;
    logic [2:0]  op;
    logic [31:0] addr;
    logic        ov;
    for (int i = 0; i < 24; i++) begin
      op   = 3'($urandom_range(0, 7));
      addr = $urandom_range(0, 32'h3010);
      if ($urandom_range(0, 3) == 0) addr = 32'h7F00 + $urandom_range(0, 31);
      ov   = ($urandom_range(0, 9) == 0);
      ack  = $urandom_range(1, 3);
      do_access(op, addr, ov, $urandom, $urandom, ack, 1'b0, st, rq);
      check_cnt("b2b_stall", st, (m_exc(op, addr, ov) != 5'd0) ? 1 : ack + 1);
    end
    go_idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_word();
    test_load_ext();
    test_exceptions();
    test_overflow();
    test_flush();
    test_reset_mid_req();
    test_timeout();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
